// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Constants shared by the whack-a-mole hit arbiter and the game FSM.
//   NUM_BTN_DEF     default number of mole buttons
//   LOCKOUT_CYC_DEF default per-button re-trigger lockout, in clk cycles
//   DEB_CYC_DEF     cycles a synchronised button level must stay stable
//                   before the debouncer accepts it
//   idx_w(n)        width of a button index for n buttons (at least 1 bit)
// -----------------------------------------------------------------------------
package whack_pkg;

   localparam int NUM_BTN_DEF     = 8;
   localparam int LOCKOUT_CYC_DEF = 16;
   localparam int DEB_CYC_DEF     = 3;

   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button.sv
// -----------------------------------------------------------------------------
// button
// Debounce and press-edge stage for one raw push button.
// The raw level is synchronised through two flops, then must differ from the
// accepted level for DEB_CYC consecutive cycles before it is accepted. A
// registered one-cycle press pulse is produced on the accepted rising edge.
// Latency from raw rising (setup before edge 0) to press high: after edge 4
// for DEB_CYC = 3.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (returns to idle, level 0)
//   raw    raw button level, asynchronous to clk
//   press  one-cycle pulse per accepted press
// -----------------------------------------------------------------------------
module button
   import whack_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam logic [3:0] CNT_MAX = 4'(DEB_CYC - 1);

   if (DEB_CYC < 1 || DEB_CYC > 16) begin : g_bad_deb
      $error("button: DEB_CYC out of range 1..16");
   end

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       stable_q, stable_d;
   logic [3:0] cnt_q, cnt_d;
   logic       press_q, press_d;

   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = 4'd0;
      press_d  = 1'b0;
      // Any cycle where the synchronised level agrees with the accepted level
      // restarts the stability count, so glitches never accumulate.
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            press_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= 4'd0;
         press_q  <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/hit_arbiter.sv
// -----------------------------------------------------------------------------
// hit_arbiter
// Debounces NUM_BTN raw mole buttons, latches each press as a pending hit and
// issues hits one at a time to the game logic over a valid/ready handshake,
// round-robin from a rotating pointer.
// Optional feature: define HIT_ARB_LOCKOUT_EN to add a per-button lockout
// counter, loaded with LOCKOUT_CYC on a grant; presses on a locked button are
// dropped silently.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   raw_button  raw buttons, active high, asynchronous
//   hit_ready   game logic accepts the presented hit
//   hit_valid   hit presented
//   hit_idx     index of the presented hit
//   pending     latched hits not yet issued
//   overflow    one-cycle pulse when a press is lost
// -----------------------------------------------------------------------------
module hit_arbiter
   import whack_pkg::*;
#(
   parameter  int NUM_BTN     = NUM_BTN_DEF,
   parameter  int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
   localparam int IDX_W       = idx_w(NUM_BTN)
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] raw_button,
   input  logic               hit_ready,
   output logic               hit_valid,
   output logic [IDX_W-1:0]   hit_idx,
   output logic [NUM_BTN-1:0] pending,
   output logic               overflow
);

   // Candidate index needs one spare bit so ptr + k can exceed NUM_BTN-1
   // before being folded back.
   localparam int CW = IDX_W + 1;

   if (NUM_BTN < 2 || NUM_BTN > 16) begin : g_bad_num
      $error("hit_arbiter: NUM_BTN out of range 2..16");
   end
   if (LOCKOUT_CYC < 1 || LOCKOUT_CYC > 255) begin : g_bad_lock
      $error("hit_arbiter: LOCKOUT_CYC out of range 1..255");
   end

   logic [NUM_BTN-1:0] p;
   logic [NUM_BTN-1:0] p_eff;
   logic [NUM_BTN-1:0] gnt_vec;
   logic [NUM_BTN-1:0] pending_q, pending_d;
   logic               hit_valid_q, hit_valid_d;
   logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
   logic               overflow_q, overflow_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic               slot_free;
   logic               gnt_any;
   logic               gnt_found;
   logic [IDX_W-1:0]   gnt_idx;
   logic [CW-1:0]      cand;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button u_button (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_button[gi]),
         .press (p[gi])
      );
   end

`ifdef HIT_ARB_LOCKOUT_EN
   logic [NUM_BTN-1:0] locked;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_lock
      logic [7:0] lock_q, lock_d;

      always_comb begin
         lock_d = lock_q;
         if (gnt_vec[gi]) begin
            lock_d = 8'(LOCKOUT_CYC);
         end else if (lock_q != 8'd0) begin
            lock_d = lock_q - 8'd1;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            lock_q <= 8'd0;
         end else begin
            lock_q <= lock_d;
         end
      end

      assign locked[gi] = (lock_q != 8'd0);
   end

   assign p_eff = p & ~locked;
`else
   assign p_eff = p;
`endif

   // Round-robin search: first pending bit at or above ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_BTN; k++) begin
         cand = {1'b0, ptr_q} + CW'(k);
         if (cand >= CW'(NUM_BTN)) begin
            cand = cand - CW'(NUM_BTN);
         end
         if (!gnt_found && pending_q[cand[IDX_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDX_W-1:0];
         end
      end
   end

   assign slot_free = !hit_valid_q || hit_ready;
   assign gnt_any   = slot_free && gnt_found;
   assign gnt_vec   = gnt_any ? (NUM_BTN'(1) << gnt_idx) : '0;

   always_comb begin
      // A press landing on the bit being granted this cycle is a fresh event:
      // it re-sets the bit and is not counted as lost.
      pending_d   = (pending_q & ~gnt_vec) | p_eff;
      overflow_d  = |(p_eff & pending_q & ~gnt_vec);
      hit_valid_d = gnt_any || (hit_valid_q && !hit_ready);
      hit_idx_d   = gnt_any ? gnt_idx : hit_idx_q;
      ptr_d       = ptr_q;
      if (gnt_any) begin
         ptr_d = (gnt_idx == IDX_W'(NUM_BTN - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         hit_valid_q <= 1'b0;
         hit_idx_q   <= '0;
         overflow_q  <= 1'b0;
         ptr_q       <= '0;
      end else begin
         pending_q   <= pending_d;
         hit_valid_q <= hit_valid_d;
         hit_idx_q   <= hit_idx_d;
         overflow_q  <= overflow_d;
         ptr_q       <= ptr_d;
      end
   end

   assign hit_valid = hit_valid_q;
   assign hit_idx   = hit_idx_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: doc/hit_arbiter.md
HIT_ARBITER -- requirements
Module: hit_arbiter

Interface
REQ-001 Parameter NUM_BTN, default 8: number of mole buttons, legal range 2..16.
REQ-002 Parameter LOCKOUT_CYC, default 16: per-button re-trigger lockout in clk cycles, legal range 1..255; used only when HIT_ARB_LOCKOUT_EN is defined.
REQ-003 clk  input  1  system clock; the block's only clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 raw_button  input  NUM_BTN  raw hardware buttons, active high, asynchronous to clk.
REQ-006 hit_ready  input  1  game logic accepts the current hit.
REQ-007 hit_valid  output  1  hit event available.
REQ-008 hit_idx  output  IDX_W  index of the hit button; IDX_W = clog2(NUM_BTN).
REQ-009 pending  output  NUM_BTN  per-button latched, not-yet-issued hits.
REQ-010 overflow  output  1  one-cycle pulse when a hit is lost.

Function
REQ-011 Each raw_button bit SHALL pass through its own debounce/edge stage, producing a one-cycle press pulse p[i].
REQ-012 p[i] at cycle t SHALL set pending[i] at t+1.
REQ-013 If p[i] occurs while pending[i]=1 and bit i is not granted that cycle, the block SHALL pulse overflow at t+1 and leave pending[i]=1.
REQ-014 Output slot is free when hit_valid=0, or when hit_valid=1 and hit_ready=1 in the same cycle.
REQ-015 When the slot is free and pending is nonzero, the block SHALL grant exactly one bit, round-robin, searching from index ptr upward with wrap from NUM_BTN-1 to 0.
REQ-016 On a grant of i: hit_valid=1 and hit_idx=i on the next cycle, pending[i] cleared, ptr = (i+1) mod NUM_BTN.
REQ-017 Minimum latency SHALL be p[i] at t -> hit_valid at t+2.
REQ-018 hit_valid and hit_idx SHALL hold stable while hit_valid=1 and hit_ready=0.
REQ-019 With hit_valid=1 and hit_ready=1, a new grant SHALL present back-to-back on the next cycle; otherwise hit_valid falls to 0.
REQ-020 p[i] in the same cycle as a grant of i SHALL leave pending[i]=1 (a new event), with no overflow.
REQ-021 Simultaneous presses on several buttons SHALL all set their pending bits; no press is lost.
REQ-022 hit_ready while hit_valid=0 SHALL be ignored.

Reset
REQ-023 rst_n low SHALL asynchronously force hit_valid=0, hit_idx=0, pending=0, overflow=0, ptr=0, all debounce state idle and all lockout counters 0.
REQ-024 Reset mid-operation SHALL discard all pending and presented hits; no hit SHALL appear after release until a new press completes debounce.

Configuration
REQ-025 With macro HIT_ARB_LOCKOUT_EN defined, a grant of i SHALL load lockout counter i with LOCKOUT_CYC and count it down once per cycle; p[i] while the counter is nonzero SHALL be dropped silently, with no pending set and no overflow.
REQ-026 Without HIT_ARB_LOCKOUT_EN, no lockout counters SHALL exist and every p[i] SHALL be processed per REQ-012..REQ-020.

Structure
REQ-027 Package whack_pkg SHALL hold the NUM_BTN default, the LOCKOUT_CYC default and the IDX_W function/constant shared with the game FSM.
REQ-028 The block SHALL instantiate the existing debounce sub-module button once per bit via a generate loop; the arbitration and lockout logic SHALL stay in hit_arbiter.

Verification
REQ-029 Press button 3, hit_ready=1 -> hit_valid 2 cycles after p[3], hit_idx=3, pending[3] cleared.
REQ-030 Buttons 1, 5 and 6 pulse in the same cycle with ptr=0 and hit_ready=1 -> issued in order 1, 5, 6 on consecutive cycles; ptr ends at 7.
REQ-031 hit_ready=0 with hit_idx=2 held, press 2 again twice -> first press sets pending[2], second pulses overflow once; hit_idx stays 2 throughout.
REQ-032 HIT_ARB_LOCKOUT_EN defined, LOCKOUT_CYC=16, button 4 granted, re-press 10 cycles later -> dropped; re-press 20 cycles later -> issued.
REQ-033 Assert rst_n low while hit_valid=1 and pending=8'h0A -> all outputs 0 immediately; no hit after release.
REQ-034 Grant of 7 coincident with a new p[7] -> pending[7] stays 1, no overflow, ptr wraps to 0.
